// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV64I ALU decode stage with 2-entry skid buffer
//
// Decodes OP, OP-32, OP-IMM, OP-IMM-32, LUI and AUIPC into an ALU op code,
// packed immediate, control flags and register indices, then registers the
// result behind a main/skid buffer pair so in_ready is a flop output.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   flush                   drop every buffered entry (and a same-cycle accept)
//   in_valid/in_ready       upstream handshake; in_inst, in_pc payload
//   out_valid/out_ready     ALU-side handshake
//   inst_name, imm, pc_out  op code, packed immediate, entry PC
//   ADDorSUB, typeI,
//   typeSigned, typeWord    ALU control flags
//   rs1_idx, rs2_idx,
//   rd_idx                  register indices
//   illegal                 encoding not handled by this stage
module alu_decode_stage #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           inst_name,
  output logic [19:0]          imm,
  output logic [XLEN-1:0]      pc_out,
  output logic                 ADDorSUB,
  output logic                 typeI,
  output logic                 typeSigned,
  output logic                 typeWord,
  output logic [REG_IDX_W-1:0] rs1_idx,
  output logic [REG_IDX_W-1:0] rs2_idx,
  output logic [REG_IDX_W-1:0] rd_idx,
  output logic                 illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ADD = 5'd0,  ADDW = 5'd1,  SUB = 5'd2,  SUBW = 5'd3;
  localparam logic [4:0] SLL = 5'd4,  SLLW = 5'd5,  SLT = 5'd6,  SLTU = 5'd7;
  localparam logic [4:0] XOR_OP = 5'd8, SRL = 5'd9, SRLW = 5'd10, SRA = 5'd11;
  localparam logic [4:0] SRAW = 5'd12, OR_OP = 5'd13, AND_OP = 5'd14;
  localparam logic [4:0] ADDI = 5'd15, ADDIW = 5'd16, SLTI = 5'd17, SLTIU = 5'd18;
  localparam logic [4:0] XORI = 5'd19, ORI = 5'd20, ANDI = 5'd21;
  localparam logic [4:0] SLLI = 5'd22, SLLIW = 5'd23, SRLI = 5'd24, SRLIW = 5'd25;
  localparam logic [4:0] SRAI = 5'd26, SRAIW = 5'd27, LUI = 5'd28, AUIPC = 5'd29;

  typedef struct packed {
    logic [4:0]           op;
    logic [19:0]          imm;
    logic                 add_sub;
    logic                 type_i;
    logic                 type_signed;
    logic                 type_word;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 illegal;
  } dec_t;

  dec_t            dec;
  dec_t            main_dec, skid_dec;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic            main_valid, skid_valid, in_ready_q;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    dec.add_sub = 1'b1;
    dec.rs1 = in_inst[19:15];
    dec.rd  = in_inst[11:7];
    case (opcode)
      OPC_OP, OPC_OP32: begin
        dec.type_word = (opcode == OPC_OP32);
        dec.rs2 = in_inst[24:20];
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          case (f3)
            3'b000: dec.op = dec.type_word ? ADDW : ADD;
            3'b001: dec.op = dec.type_word ? SLLW : SLL;
            3'b010: begin dec.op = SLT; dec.type_signed = 1'b1; legal = !dec.type_word; end
            3'b011: begin dec.op = SLTU;   legal = !dec.type_word; end
            3'b100: begin dec.op = XOR_OP; legal = !dec.type_word; end
            3'b101: dec.op = dec.type_word ? SRLW : SRL;
            3'b110: begin dec.op = OR_OP;  legal = !dec.type_word; end
            default: begin dec.op = AND_OP; legal = !dec.type_word; end
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) begin
            legal = 1'b1;
            dec.op = dec.type_word ? SUBW : SUB;
            dec.add_sub = 1'b0;
          end else if (f3 == 3'b101) begin
            legal = 1'b1;
            dec.op = dec.type_word ? SRAW : SRA;
          end
        end
      end
      OPC_IMM: begin
        dec.type_i = 1'b1;
        dec.imm    = {in_inst[31:20], 8'h00};
        legal      = 1'b1;
        case (f3)
          3'b000: dec.op = ADDI;
          3'b010: begin dec.op = SLTI; dec.type_signed = 1'b1; end
          3'b011: dec.op = SLTIU;
          3'b100: dec.op = XORI;
          3'b110: dec.op = ORI;
          3'b111: dec.op = ANDI;
          3'b001: begin dec.op = SLLI; legal = (in_inst[31:26] == 6'b000000); end
          default: begin
            if (in_inst[31:26] == 6'b000000)      dec.op = SRLI;
            else if (in_inst[31:26] == 6'b010000) dec.op = SRAI;
            else                                  legal = 1'b0;
          end
        endcase
      end
      OPC_IMM32: begin
        dec.type_i    = 1'b1;
        dec.type_word = 1'b1;
        dec.imm       = {in_inst[31:20], 8'h00};
        // W-form shifts: bit 25 is part of the funct7 check, not the shamt
        case (f3)
          3'b000: begin dec.op = ADDIW; legal = 1'b1; end
          3'b001: begin dec.op = SLLIW; legal = (f7 == 7'b0000000); end
          3'b101: begin
            if (f7 == 7'b0000000)      begin dec.op = SRLIW; legal = 1'b1; end
            else if (f7 == 7'b0100000) begin dec.op = SRAIW; legal = 1'b1; end
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        legal   = 1'b1;
        dec.op  = (opcode == OPC_LUI) ? LUI : AUIPC;
        dec.imm = in_inst[31:12];
        dec.rs1 = '0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Buffer control. An accept implies the skid is empty (in_ready mirrors
  // !skid_valid), so loading main from skid and from the input never collide.
  logic accept, drain, main_load_in, main_from_skid, skid_load;
  logic main_valid_n, skid_valid_n;

  assign accept         = in_valid & in_ready_q;
  assign drain          = main_valid & out_ready;
  assign main_load_in   = accept & (!main_valid | (drain & !skid_valid));
  assign skid_load      = accept & main_valid & !drain;
  assign main_from_skid = drain & skid_valid;
  assign main_valid_n   = main_load_in | main_from_skid | (main_valid & !drain);
  assign skid_valid_n   = skid_load | (skid_valid & !drain);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
      main_dec   <= '0;
      skid_dec   <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready_q <= !skid_valid_n;
      if (main_from_skid) begin
        main_dec <= skid_dec;
        main_pc  <= skid_pc;
      end else if (main_load_in) begin
        main_dec <= dec;
        main_pc  <= in_pc;
      end
      if (skid_load) begin
        skid_dec <= dec;
        skid_pc  <= in_pc;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid;
  assign inst_name  = main_dec.op;
  assign imm        = main_dec.imm;
  assign pc_out     = main_pc;
  assign ADDorSUB   = main_dec.add_sub;
  assign typeI      = main_dec.type_i;
  assign typeSigned = main_dec.type_signed;
  assign typeWord   = main_dec.type_word;
  assign rs1_idx    = main_dec.rs1;
  assign rs2_idx    = main_dec.rs2;
  assign rd_idx     = main_dec.rd;
  assign illegal    = main_dec.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed bench for alu_decode_stage
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc, pc_out;
  logic [4:0]  inst_name, rs1_idx, rs2_idx, rd_idx;
  logic [19:0] imm;
  logic        ADDorSUB, typeI, typeSigned, typeWord, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(64), .REG_IDX_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_name(inst_name), .imm(imm), .pc_out(pc_out),
    .ADDorSUB(ADDorSUB), .typeI(typeI), .typeSigned(typeSigned), .typeWord(typeWord),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx), .illegal(illegal)
  );

  // Presents one instruction for a single cycle with out_ready high and
  // returns at the following negedge, when the decoded entry is on the output.
  task automatic drive_one(input logic [31:0] inst, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    total++; if ({inst_name, imm, pc_out, rd_idx, rs1_idx, rs2_idx, illegal, ADDorSUB, typeI} !== '0) begin
      bad++; $display("FAIL rst_data got=%0h/%0h/%0h want=0", inst_name, imm, pc_out);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_decode;
    drive_one(32'hFFF10093, 64'h1000); // ADDI x1,x2,-1
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
    total++; if ({inst_name, imm, typeI, ADDorSUB, typeSigned, typeWord} !== {5'd15, 20'hFFF00, 4'b1100}) begin
      bad++; $display("FAIL addi_dec got=%0d/%0h/%b%b%b%b want=15/fff00/1100", inst_name, imm, typeI, ADDorSUB, typeSigned, typeWord);
    end
    total++; if ({rs1_idx, rs2_idx, rd_idx, pc_out} !== {5'd2, 5'd0, 5'd1, 64'h1000}) begin
      bad++; $display("FAIL addi_regs got=%0d/%0d/%0d/%0h want=2/0/1/1000", rs1_idx, rs2_idx, rd_idx, pc_out);
    end

    drive_one(32'h405201B3, 64'h1004); // SUB x3,x4,x5
    total++; if ({inst_name, ADDorSUB, typeI, imm, illegal} !== {5'd2, 1'b0, 1'b0, 20'h0, 1'b0}) begin
      bad++; $display("FAIL sub_dec got=%0d/%b/%b/%0h want=2/0/0/0", inst_name, ADDorSUB, typeI, imm);
    end
    total++; if ({rs1_idx, rs2_idx, rd_idx} !== {5'd4, 5'd5, 5'd3}) begin
      bad++; $display("FAIL sub_regs got=%0d/%0d/%0d want=4/5/3", rs1_idx, rs2_idx, rd_idx);
    end

    drive_one(32'h4033D31B, 64'h1008); // SRAIW x6,x7,3
    total++; if ({inst_name, typeI, typeWord, imm, rs1_idx, rs2_idx, rd_idx} !== {5'd27, 1'b1, 1'b1, 20'h40300, 5'd7, 5'd0, 5'd6}) begin
      bad++; $display("FAIL sraiw got=%0d/%b/%b/%0h/%0d/%0d want=27/1/1/40300/7/6", inst_name, typeI, typeWord, imm, rs1_idx, rd_idx);
    end

    drive_one(32'h123452B7, 64'h100C); // LUI x5,0x12345
    total++; if ({inst_name, imm, rs1_idx, rd_idx, typeI} !== {5'd28, 20'h12345, 5'd0, 5'd5, 1'b0}) begin
      bad++; $display("FAIL lui got=%0d/%0h/%0d/%0d want=28/12345/0/5", inst_name, imm, rs1_idx, rd_idx);
    end

    drive_one(32'h003120B3, 64'h1010); // SLT x1,x2,x3
    total++; if ({inst_name, typeSigned, typeWord, rs2_idx} !== {5'd6, 1'b1, 1'b0, 5'd3}) begin
      bad++; $display("FAIL slt got=%0d/%b/%b/%0d want=6/1/0/3", inst_name, typeSigned, typeWord, rs2_idx);
    end

    drive_one(32'h02208033, 64'h1014); // MUL: M-extension is illegal here
    total++; if ({out_valid, illegal, inst_name, rd_idx, imm, ADDorSUB, pc_out} !== {1'b1, 1'b1, 5'd0, 5'd0, 20'h0, 1'b0, 64'h1014}) begin
      bad++; $display("FAIL mul_illegal got=v%b i%b %0d/%0d/%0h want=v1 i1 0/0/0", out_valid, illegal, inst_name, rd_idx, imm);
    end

    drive_one(32'h0200109B, 64'h1018); // SLLIW with inst[25]=1
    total++; if ({illegal, inst_name, rd_idx, typeWord} !== {1'b1, 5'd0, 5'd0, 1'b0}) begin
      bad++; $display("FAIL slliw_b25 got=i%b %0d/%0d want=i1 0/0", illegal, inst_name, rd_idx);
    end
    @(negedge clk); // drain last entry
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_pc [4];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic acc, drn;
    for (int k = 0; k < 4; k++) exp_pc[k] = 64'h2000 + 64'(4 * k);
    while (got < 4 && cyc < 40) begin
      in_valid  = (sent < 4);
      in_inst   = (32'(sent) << 20) | (32'(sent + 1) << 7) | 32'h13;
      in_pc     = 64'h2000 + 64'(4 * sent);
      out_ready = (cyc >= 6);
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b0 || sent != 2) begin
          bad++; $display("FAIL bp_ready_drop in_ready=%0b accepted=%0d want 0/2", in_ready, sent);
        end
      end
      if (cyc == 5) begin
        total++; if (sent != 2 || out_valid !== 1'b1 || pc_out !== 64'h2000) begin
          bad++; $display("FAIL bp_hold accepted=%0d pc=%0h want 2/2000", sent, pc_out);
        end
      end
      if (cyc >= 6 && !out_valid) begin
        total++; bad++; $display("FAIL bp_gap cycle=%0d got=%0d want out_valid=1", cyc, got);
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        total++; if (pc_out !== exp_pc[got] || rd_idx !== 5'(got + 1) || inst_name !== 5'd15) begin
          bad++; $display("FAIL bp_order idx=%0d got pc=%0h rd=%0d want pc=%0h rd=%0d", got, pc_out, rd_idx, exp_pc[got], got + 1);
        end
      end
      @(posedge clk);
      if (acc) sent++;
      if (drn) got++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive_one(32'h00100093, 64'h3000);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00200113; in_pc = 64'h3004;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre in_ready=%0b out_valid=%0b want 0/1", in_ready, out_valid);
    end
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 64'hDEAD0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cycle=%0d pc=%0h want no output", i, pc_out); end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive_one(32'h4033D31B, 64'h4000);
    in_valid = 1'b1; in_inst = 32'h405201B3; in_pc = 64'h4004;
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b00) begin
      bad++; $display("FAIL midrst_hs out_valid=%0b in_ready=%0b want 0/0", out_valid, in_ready);
    end
    total++; if ({inst_name, imm, pc_out, rs1_idx, rs2_idx, rd_idx, typeI, typeWord, ADDorSUB, typeSigned, illegal} !== '0) begin
      bad++; $display("FAIL midrst_data got=%0d/%0h/%0h/%0d want all 0", inst_name, imm, pc_out, rd_idx);
    end
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL midrst_release out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
